uart_rx_frame_ctrl: RTL

Frame-level controller that sits directly behind the UART byte receiver (uart_rxd). It consumes completed bytes and parses them as frames: header 0x55 0xAA, length, payload, checksum. It streams payload bytes downstream and reports frame success or failure. It also configures the receiver's baud selection through a dedicated baud-change command frame.

---
 rtl/uart_rx_frame_ctrl_if.sv | 53 +++++
 rtl/uart_rx_frame_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl_if.sv
// rtl/uart_rx_frame_ctrl_if.sv - signal bundle between the UART byte receiver side and the frame controller
//
// Purpose : groups the byte input, payload stream, frame status and baud select
//           of uart_rx_frame_ctrl into one interface.
// Signals :
//   rx_data    [7:0] byte from receiver
//   rx_done          one-cycle pulse, rx_data valid
//   bps_set    [1:0] baud select driven back to the receiver
//   pld_data   [7:0] payload byte
//   pld_valid        one-cycle strobe for pld_data
//   frame_done       one-cycle pulse, frame accepted with good checksum
//   frame_err        one-cycle pulse, frame aborted
//   err_code   [1:0] 0 none, 1 checksum, 2 length overflow, 3 timeout
//   busy             controller is inside a frame
// Modports:
//   master : receiver/environment side (drives rx_data/rx_done)
//   slave  : frame controller side

interface uart_rx_frame_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [1:0] bps_set;
   logic [7:0] pld_data;
   logic       pld_valid;
   logic       frame_done;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   modport master (
      output rx_data,
      output rx_done,
      input  bps_set,
      input  pld_data,
      input  pld_valid,
      input  frame_done,
      input  frame_err,
      input  err_code,
      input  busy
   );

   modport slave (
      input  rx_data,
      input  rx_done,
      output bps_set,
      output pld_data,
      output pld_valid,
      output frame_done,
      output frame_err,
      output err_code,
      output busy
   );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - frame parser behind the UART byte receiver
//
// Purpose : parses received bytes as frames 0x55 0xAA LEN PAYLOAD[LEN] CHK,
//           streams the payload, reports frame success/failure and applies
//           the baud-change command (LEN=1, payload 0xB0..0xB3) to bps_set.
//           CHK is the 8-bit wrap-around sum of LEN and all payload bytes.
// Ports   :
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    uart_rx_frame_ctrl_if.slave: rx_data/rx_done in; bps_set,
//          pld_data/pld_valid, frame_done, frame_err, err_code, busy out
// Parameters:
//   MAX_LEN      largest legal payload length (1..255)
//   TIMEOUT_CYC  inter-byte timeout in clk cycles while a frame is open (>= 2)
//   BPS_DEFAULT  bps_set value after reset
// Configuration:
//   UART_FRAME_TIMEOUT_EN  when defined, an open frame that sees no byte for
//                          TIMEOUT_CYC cycles is aborted with err_code=3;
//                          when undefined, an open frame waits indefinitely.

module uart_rx_frame_ctrl #(
   parameter int         MAX_LEN     = 16,
   parameter int         TIMEOUT_CYC = 500000,
   parameter logic [1:0] BPS_DEFAULT = 2'b10
) (
   input logic                 clk,
   input logic                 rst_n,
   uart_rx_frame_ctrl_if.slave bus
);

   localparam logic [7:0] HDR1    = 8'h55;
   localparam logic [7:0] HDR2    = 8'hAA;
   localparam logic [8:0] MAX_LV  = 9'(MAX_LEN);

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_CHK  = 2'd1;
   localparam logic [1:0] ERR_LEN  = 2'd2;
`ifdef UART_FRAME_TIMEOUT_EN
   localparam logic [1:0] ERR_TMO  = 2'd3;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR2,
      S_LEN,
      S_PAYLOAD,
      S_CHK
   } state_t;

   state_t     state_q;
   state_t     state_d;

   logic [7:0] len_cnt;
   logic [7:0] chk_sum;
   logic       len_one;
   logic [7:0] pld_data_q;
   logic       pld_valid_q;
   logic       frame_done_q;
   logic       frame_err_q;
   logic [1:0] err_code_q;
   logic [1:0] bps_q;

   // Per-cycle events decided by the FSM and applied by the datapath.
   logic       len_load;
   logic       pld_fire;
   logic       done_fire;
   logic       err_fire;
   logic [1:0] err_val;
   logic       baud_fire;
   logic       timeout_hit;

`ifdef UART_FRAME_TIMEOUT_EN
   localparam int             TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0]  TMO_FIRE = TW'(TIMEOUT_CYC - 2);

   logic [TW-1:0] tmo_cnt;

   // The counter holds 0 in the cycle after a byte and counts up while a
   // frame is open. Firing when it is about to reach TIMEOUT_CYC-1 puts
   // frame_err exactly TIMEOUT_CYC cycles after the last rx_done cycle. A
   // byte in the same cycle takes priority and clears the counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (bus.rx_done || (state_d == S_IDLE)) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state_q != S_IDLE) && !bus.rx_done && (tmo_cnt == TMO_FIRE);
`else
   assign timeout_hit = 1'b0;
`endif

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and events
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      len_load  = 1'b0;
      pld_fire  = 1'b0;
      done_fire = 1'b0;
      err_fire  = 1'b0;
      err_val   = ERR_NONE;
      baud_fire = 1'b0;

      if (bus.rx_done) begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.rx_data == HDR1) begin
                  state_d = S_HDR2;
               end
            end

            S_HDR2: begin
               // A repeated 0x55 may itself be the real first header byte.
               if (bus.rx_data == HDR2) begin
                  state_d = S_LEN;
               end else if (bus.rx_data != HDR1) begin
                  state_d = S_IDLE;
               end
            end

            S_LEN: begin
               if ({1'b0, bus.rx_data} > MAX_LV) begin
                  err_fire = 1'b1;
                  err_val  = ERR_LEN;
                  state_d  = S_IDLE;
               end else begin
                  len_load = 1'b1;
                  state_d  = (bus.rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
               end
            end

            S_PAYLOAD: begin
               pld_fire = 1'b1;
               if (len_cnt == 8'd1) begin
                  state_d = S_CHK;
               end
            end

            S_CHK: begin
               if (bus.rx_data == chk_sum) begin
                  done_fire = 1'b1;
                  // Baud command: single payload byte 0b1011_00xx.
                  if (len_one && (pld_data_q[7:2] == 6'b101100)) begin
                     baud_fire = 1'b1;
                  end
               end else begin
                  err_fire = 1'b1;
                  err_val  = ERR_CHK;
               end
               state_d = S_IDLE;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end else if (timeout_hit) begin
`ifdef UART_FRAME_TIMEOUT_EN
         err_fire = 1'b1;
         err_val  = ERR_TMO;
`endif
         state_d  = S_IDLE;
      end
   end

   // ------------------------------------------------------------------
   // Datapath and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_cnt      <= 8'd0;
         chk_sum      <= 8'd0;
         len_one      <= 1'b0;
         pld_data_q   <= 8'd0;
         pld_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= ERR_NONE;
         bps_q        <= BPS_DEFAULT;
      end else begin
         pld_valid_q  <= pld_fire;
         frame_done_q <= done_fire;
         frame_err_q  <= err_fire;

         if (pld_fire) begin
            pld_data_q <= bus.rx_data;
         end

         if (len_load) begin
            len_cnt <= bus.rx_data;
            chk_sum <= bus.rx_data;
            len_one <= (bus.rx_data == 8'd1);
         end else if (pld_fire) begin
            len_cnt <= len_cnt - 8'd1;
            chk_sum <= chk_sum + bus.rx_data;
         end

         // err_code is sticky between frame outcomes.
         if (done_fire) begin
            err_code_q <= ERR_NONE;
         end else if (err_fire) begin
            err_code_q <= err_val;
         end

         // pld_data_q still holds the single payload byte of a LEN=1 frame.
         if (baud_fire) begin
            bps_q <= pld_data_q[1:0];
         end
      end
   end

   assign bus.bps_set    = bps_q;
   assign bus.pld_data   = pld_data_q;
   assign bus.pld_valid  = pld_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.err_code   = err_code_q;
   assign bus.busy       = (state_q != S_IDLE);

endmodule
